// File: rtl/aes_pkg.sv
// Shared AES constants and GF(2^8) helpers for the round-key generator.
// The S-box is computed (inverse as x^254, then the affine map) rather than tabulated.
package aes_pkg;

  typedef enum logic [1:0] {
    ALG_128  = 2'b00,
    ALG_192  = 2'b01,
    ALG_256  = 2'b10,
    ALG_RSVD = 2'b11
  } alg_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXPAND,
    S_DONE
  } state_e;

  localparam logic [3:0] NK_128 = 4'd4;
  localparam logic [3:0] NK_192 = 4'd6;
  localparam logic [3:0] NK_256 = 4'd8;
  localparam logic [3:0] NR_128 = 4'd10;
  localparam logic [3:0] NR_192 = 4'd12;
  localparam logic [3:0] NR_256 = 4'd14;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa;
    p  = 8'h00;
    aa = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] s, r;
    s = x;
    r = 8'h01;
    // r accumulates x^(2+4+...+128) = x^254, the field inverse (0 maps to 0)
    for (int k = 0; k < 7; k++) begin
      s = gmul(s, s);
      r = gmul(r, s);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^
           {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

endpackage

// File: rtl/aes_sub_word.sv
// SubWord: four parallel S-box lookups on a 32-bit word, purely combinational.
module aes_sub_word
  import aes_pkg::*;
(
  input  logic [31:0] din,
  output logic [31:0] dout
);

  for (genvar b = 0; b < 4; b++) begin : g_lane
    assign dout[8*b +: 8] = sbox(din[8*b +: 8]);
  end

endmodule

// File: rtl/aes_key_schedule_seq.sv
// Iterative AES-128/192/256 key expansion, one word per clock, with a registered round-key read port.
// AES_KEY_DEC_ORDER_EN adds rd_dec, which reverses the round-key order for the decrypt datapath.
module aes_key_schedule_seq
  import aes_pkg::*;
#(
  parameter int MAX_NK    = 8,
  parameter int MAX_WORDS = 60,
  parameter int IDX_W     = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [32*MAX_NK-1:0]  key,
  input  logic [1:0]            algorithm,
  output logic                  busy,
  output logic                  done,
  output logic                  ready,
  output logic                  err,
  input  logic [IDX_W-1:0]      rd_idx,
`ifdef AES_KEY_DEC_ORDER_EN
  input  logic                  rd_dec,
`endif
  output logic [127:0]          rd_key,
  output logic                  rd_valid
);

  localparam int WI = $clog2(MAX_WORDS);
  localparam int CW = $clog2(MAX_NK);

  state_e           state;
  logic [3:0]       nk, nk_in, nr_in;
  logic [IDX_W-1:0] nr, eff_idx;
  logic [WI-1:0]    wi, last_w;
  logic [CW-1:0]    cnt;
  logic [7:0]       rcon;
  logic [31:0]      w [MAX_WORDS];
  logic [31:0]      prev, back, sub_in, sub_out, temp, new_w;
  logic             alg_ok;

  always_comb begin
    nk_in = NK_128;
    nr_in = NR_128;
    case (alg_e'(algorithm))
      ALG_192: begin nk_in = NK_192; nr_in = NR_192; end
      ALG_256: begin nk_in = NK_256; nr_in = NR_256; end
      default: ;
    endcase
  end

  assign alg_ok = (alg_e'(algorithm) != ALG_RSVD);
  assign last_w = WI'({nr, 2'b11});

  // cnt tracks i mod Nk; cnt == 0 marks the RotWord/Rcon step
  assign prev   = w[wi - WI'(1)];
  assign back   = w[wi - WI'(nk)];
  assign sub_in = (cnt == '0) ? {prev[23:0], prev[31:24]} : prev;

  aes_sub_word u_sub (.din(sub_in), .dout(sub_out));

  always_comb begin
    temp = prev;
    if (cnt == '0)                           temp = sub_out ^ {rcon, 24'h0};
    else if (nk == NK_256 && cnt == CW'(4))  temp = sub_out;
  end

  assign new_w = back ^ temp;

  always_ff @(posedge clk) begin
    if (state == S_IDLE && start && alg_ok) begin
      for (int k = 0; k < MAX_NK; k++)
        if (k < int'(nk_in)) w[k] <= key[32*MAX_NK-1-32*k -: 32];
    end else if (state == S_EXPAND) begin
      w[wi] <= new_w;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      ready <= 1'b0;
      err   <= 1'b0;
      nk    <= NK_128;
      nr    <= '0;
      wi    <= '0;
      cnt   <= '0;
      rcon  <= 8'h00;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (alg_ok) begin
              nk    <= nk_in;
              nr    <= IDX_W'(nr_in);
              wi    <= WI'(nk_in);
              cnt   <= '0;
              rcon  <= 8'h01;
              busy  <= 1'b1;
              ready <= 1'b0;
              state <= S_EXPAND;
            end else begin
              err <= 1'b1;
            end
          end
        end
        S_EXPAND: begin
          wi  <= wi + WI'(1);
          cnt <= ({1'b0, cnt} == CW'(nk - 4'd1)) ? '0 : cnt + CW'(1);
          if (cnt == '0) rcon <= xtime(rcon);
          if (wi == last_w) begin
            busy  <= 1'b0;
            ready <= 1'b1;
            done  <= 1'b1;
            state <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef AES_KEY_DEC_ORDER_EN
  assign eff_idx = rd_dec ? (nr - rd_idx) : rd_idx;
`else
  assign eff_idx = rd_idx;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_key   <= '0;
    end else if (ready && rd_idx <= nr) begin
      rd_valid <= 1'b1;
      rd_key   <= {w[WI'({eff_idx, 2'b00})], w[WI'({eff_idx, 2'b01})],
                   w[WI'({eff_idx, 2'b10})], w[WI'({eff_idx, 2'b11})]};
    end else begin
      rd_valid <= 1'b0;
      rd_key   <= '0;
    end
  end

endmodule

// File: tb/tb_aes_key_schedule_seq.sv
// Directed bench for aes_key_schedule_seq using FIPS-197 key-expansion vectors.
module tb_aes_key_schedule_seq;

  logic         clk = 1'b0;
  logic         rst, start;
  logic [255:0] key;
  logic [1:0]   algorithm;
  logic         busy, done, ready, err, rd_valid;
  logic [3:0]   rd_idx;
  logic [127:0] rd_key;
`ifdef AES_KEY_DEC_ORDER_EN
  logic         rd_dec = 1'b0;
`endif

  int errors = 0;
  int checks = 0;
  int n, n0;

  localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] R128_0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] R128_1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] R128_10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] R192_12 = 128'he98ba06f448c773c8ecc720401002202;
  localparam logic [127:0] R256_14 = 128'hfe4890d1e6188d0b046df344706c631e;

  aes_key_schedule_seq dut (
    .clk(clk), .rst(rst), .start(start), .key(key), .algorithm(algorithm),
    .busy(busy), .done(done), .ready(ready), .err(err), .rd_idx(rd_idx),
`ifdef AES_KEY_DEC_ORDER_EN
    .rd_dec(rd_dec),
`endif
    .rd_key(rd_key), .rd_valid(rd_valid)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic [1:0] a, input logic [255:0] k);
    algorithm = a;
    key       = k;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  task automatic wait_done(output int cnt);
    cnt = 0;
    while (done !== 1'b1 && cnt < 200) begin
      tick();
      cnt++;
    end
  endtask

  task automatic rd(input logic [3:0] idx);
    rd_idx = idx;
    tick();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; key = '0; algorithm = 2'b00; rd_idx = '0;
    tick(); tick();
    chk("reset_busy",  128'(busy),     128'd0);
    chk("reset_done",  128'(done),     128'd0);
    chk("reset_ready", 128'(ready),    128'd0);
    chk("reset_err",   128'(err),      128'd0);
    chk("reset_valid", 128'(rd_valid), 128'd0);
    chk("reset_key",   rd_key,         128'd0);
    rst = 1'b0;

    // AES-128; key/algorithm changed after start must not matter
    do_start(2'b00, K128);
    chk("a128_busy",  128'(busy),  128'd1);
    chk("a128_ready", 128'(ready), 128'd0);
    key = ~K128; algorithm = 2'b10;
    wait_done(n);
    chk("a128_latency", 128'(n), 128'd40);
    chk("a128_ready_done", 128'(ready), 128'd1);
    chk("a128_busy_done",  128'(busy),  128'd0);
    tick();
    chk("a128_done_pulse", 128'(done), 128'd0);
    rd(4'd10); chk("a128_rk10", rd_key, R128_10); chk("a128_v10", 128'(rd_valid), 128'd1);
    rd(4'd0);  chk("a128_rk0",  rd_key, R128_0);
    rd(4'd1);  chk("a128_rk1",  rd_key, R128_1);
    rd(4'd11); chk("a128_v11",  128'(rd_valid), 128'd0); chk("a128_rk11", rd_key, 128'd0);
`ifdef AES_KEY_DEC_ORDER_EN
    rd_dec = 1'b1;
    rd(4'd0);  chk("dec_rk0",  rd_key, R128_10);
    rd(4'd10); chk("dec_rk10", rd_key, R128_0);
    rd_dec = 1'b0;
`endif

    // AES-192 with a stray start mid-expansion
    do_start(2'b01, K192);
    repeat (9) tick();
    algorithm = 2'b00; start = 1'b1;
    tick();
    start = 1'b0;
    n0 = 10;
    chk("a192_busy_mid", 128'(busy), 128'd1);
    wait_done(n);
    chk("a192_latency", 128'(n0 + n), 128'd46);
    tick();
    rd(4'd12); chk("a192_rk12", rd_key, R192_12);
    rd(4'd13); chk("a192_v13", 128'(rd_valid), 128'd0); chk("a192_rk13", rd_key, 128'd0);

    // AES-256
    do_start(2'b10, K256);
    wait_done(n);
    chk("a256_latency", 128'(n), 128'd52);
    tick();
    rd(4'd14); chk("a256_rk14", rd_key, R256_14); chk("a256_v14", 128'(rd_valid), 128'd1);

    // Reserved algorithm: err pulse, schedule kept
    algorithm = 2'b11; start = 1'b1;
    tick();
    start = 1'b0;
    chk("rsvd_err",   128'(err),   128'd1);
    chk("rsvd_busy",  128'(busy),  128'd0);
    chk("rsvd_ready", 128'(ready), 128'd1);
    tick();
    chk("rsvd_err_pulse", 128'(err), 128'd0);
    chk("rsvd_busy2",     128'(busy), 128'd0);
    rd(4'd14); chk("rsvd_rk14", rd_key, R256_14);

    // Reset at cycle 20 of an AES-256 run
    rd_idx = 4'd0;
    do_start(2'b10, K256);
    repeat (9) tick();
    chk("expand_rd_valid", 128'(rd_valid), 128'd0);
    repeat (10) tick();
    rst = 1'b1;
    tick();
    chk("rst_busy",  128'(busy),     128'd0);
    chk("rst_done",  128'(done),     128'd0);
    chk("rst_ready", 128'(ready),    128'd0);
    chk("rst_err",   128'(err),      128'd0);
    chk("rst_valid", 128'(rd_valid), 128'd0);
    chk("rst_key",   rd_key,         128'd0);
    rst = 1'b0;
    do_start(2'b00, K128);
    wait_done(n);
    chk("post_rst_latency", 128'(n), 128'd40);
    tick();
    rd(4'd10); chk("post_rst_rk10", rd_key, R128_10);
    rd(4'd0);  chk("post_rst_rk0",  rd_key, R128_0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
